// File: rtl/serial_byte_rx_if.sv
// serial_byte_rx_if: serial line in, handshaked parallel word out, plus error flags
interface serial_byte_rx_if #(parameter int WIDTH = 8);
    logic             sin;
    logic [WIDTH-1:0] out;
    logic             valid;
    logic             ready;
    logic             frame_err;
    logic             overrun;
    modport master (input sin, ready, output out, valid, frame_err, overrun);
    modport slave  (output sin, ready, input out, valid, frame_err, overrun);
endinterface

// File: rtl/serial_byte_rx.sv
// serial_byte_rx: one-bit-per-clock framed deserializer (start, WIDTH data LSB-first, stop)
module serial_byte_rx #(
    parameter int WIDTH = 8
) (
    input logic                   clk,
    input logic                   reset,
    serial_byte_rx_if.master      bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shift;
    logic             last, commit, free;
    always_comb begin
        last    = cnt == CW'(WIDTH - 1);
        state_n = state == IDLE ? (bus.sin ? IDLE : DATA) :
                  state == DATA ? (last ? STOP : DATA) : IDLE;
        commit  = state == STOP && bus.sin;
        // a word consumed on this edge frees the slot for a same-edge commit
        free    = !bus.valid || bus.ready;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            shift         <= '0;
            bus.out       <= '0;
            bus.valid     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= (state == DATA && !last) ? cnt + 1'b1 : '0;
            bus.frame_err <= state == STOP && !bus.sin;
            if (state == DATA)
                shift[cnt] <= bus.sin;
            if (commit && free) begin
                bus.out   <= shift;
                bus.valid <= 1'b1;
            end else if (bus.valid && bus.ready) begin
                bus.valid <= 1'b0;
            end
            if (commit && !free)
                bus.overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_serial_byte_rx.sv
// tb_serial_byte_rx: directed scenario tasks with hand-computed expectations
module tb_serial_byte_rx;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    serial_byte_rx_if #(.WIDTH(8)) bus ();
    serial_byte_rx #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    // every stimulus step lands 1 time unit after a rising edge
    task automatic send_bit(input logic b);
        bus.sin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_data(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.sin = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.sin = 1'b1;
        bus.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (bus.out !== 8'h00) begin errors++; $display("FAIL reset_out got %h want 00", bus.out); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", bus.frame_err); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", bus.overrun); end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 50; i++) begin
            send_bit(1'b1);
            checks++;
            if ({bus.valid, bus.frame_err, bus.overrun} !== 3'b000) begin
                errors++;
                $display("FAIL idle_flags cycle %0d got %b want 000", i, {bus.valid, bus.frame_err, bus.overrun});
            end
        end
        checks++; if (bus.out !== 8'h00) begin errors++; $display("FAIL idle_out got %h want 00", bus.out); end
    endtask

    task automatic test_single();
        bus.ready = 1'b0;
        send_data(8'hA5);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", bus.valid); end
        send_bit(1'b1);
        bus.sin = 1'b1;
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.valid); end
        checks++; if (bus.out !== 8'hA5) begin errors++; $display("FAIL single_out got %h want a5", bus.out); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL single_ferr got %b want 0", bus.frame_err); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL single_ovr got %b want 0", bus.overrun); end
        send_bit(1'b1);
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL single_hold_valid got %b want 1", bus.valid); end
        bus.ready = 1'b1;
        send_bit(1'b1);
        bus.ready = 1'b0;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL single_consume_valid got %b want 0", bus.valid); end
        checks++; if (bus.out !== 8'hA5) begin errors++; $display("FAIL single_consume_out got %h want a5", bus.out); end
    endtask

    task automatic test_frame_err();
        send_data(8'h3C);
        send_bit(1'b0);
        bus.sin = 1'b1;
        checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse got %b want 1", bus.frame_err); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got %b want 0", bus.valid); end
        checks++; if (bus.out !== 8'hA5) begin errors++; $display("FAIL ferr_out got %h want a5", bus.out); end
        send_bit(1'b1);
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_one_cycle got %b want 0", bus.frame_err); end
        send_data(8'h3C);
        send_bit(1'b1);
        bus.sin = 1'b1;
        checks++; if (bus.out !== 8'h3C) begin errors++; $display("FAIL ferr_recover_out got %h want 3c", bus.out); end
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL ferr_recover_valid got %b want 1", bus.valid); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_recover_ferr got %b want 0", bus.frame_err); end
        bus.ready = 1'b1;
        send_bit(1'b1);
        bus.ready = 1'b0;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL ferr_drain got %b want 0", bus.valid); end
    endtask

    task automatic test_overrun();
        send_data(8'h11);
        send_bit(1'b1);
        checks++; if (bus.out !== 8'h11) begin errors++; $display("FAIL ovr_first_out got %h want 11", bus.out); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_flag got %b want 0", bus.overrun); end
        send_data(8'h22);
        send_bit(1'b1);
        bus.sin = 1'b1;
        checks++; if (bus.out !== 8'h11) begin errors++; $display("FAIL ovr_out got %h want 11", bus.out); end
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", bus.valid); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", bus.overrun); end
        bus.ready = 1'b1;
        send_bit(1'b1);
        bus.ready = 1'b0;
        repeat (3) send_bit(1'b1);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL ovr_consume_valid got %b want 0", bus.valid); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", bus.overrun); end
        do_reset();
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_reset got %b want 0", bus.overrun); end
    endtask

    task automatic test_simul();
        send_data(8'h11);
        send_bit(1'b1);
        send_data(8'h22);
        bus.ready = 1'b1;
        send_bit(1'b1);
        bus.ready = 1'b0;
        bus.sin = 1'b1;
        checks++; if (bus.out !== 8'h22) begin errors++; $display("FAIL simul_out got %h want 22", bus.out); end
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL simul_valid got %b want 1", bus.valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL simul_ovr got %b want 0", bus.overrun); end
    endtask

    task automatic test_reset_mid();
        send_data(8'h5A);
        send_bit(1'b1);
        send_bit(1'b0);
        repeat (4) send_bit(1'b1);
        do_reset();
        checks++; if (bus.out !== 8'h00) begin errors++; $display("FAIL mid_out got %h want 00", bus.out); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", bus.valid); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL mid_ferr got %b want 0", bus.frame_err); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL mid_ovr got %b want 0", bus.overrun); end
        send_data(8'h81);
        send_bit(1'b1);
        bus.sin = 1'b1;
        checks++; if (bus.out !== 8'h81) begin errors++; $display("FAIL mid_next_out got %h want 81", bus.out); end
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL mid_next_valid got %b want 1", bus.valid); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL mid_next_ferr got %b want 0", bus.frame_err); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_frame_err();
        test_overrun();
        test_simul();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_byte_rx.md
# serial_byte_rx

Bit-serial receiver: deserializes a framed 1-bit input stream (start bit, WIDTH data bits LSB-first, stop bit) into a parallel word. It holds the word behind a valid/ready handshake. It is the expansion counterpart to the 8-to-1 reduction gates: one wire in, an 8-bit bus out. It feeds byte-wide consumers (I/O register, memory-mapped keyboard/port) in the CPU datapath, with one bit per clock and no oversampling.

## Interface
- WIDTH, 8, data bits per frame; the counter is sized to hold WIDTH-1.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- sin  input  1  serial line; idles at 1.
- out  output  WIDTH  last committed word; held stable while valid=1.
- valid  output  1  out holds an unconsumed word.
- ready  input  1  consumer accepts out on an edge where valid&ready=1.
- frame_err  output  1  one-cycle pulse: the stop bit was sampled as 0.
- overrun  output  1  sticky; a completed frame was dropped because out was still held.

## Operation
- Reset: state=IDLE, bit counter=0, shift register=0, out=0, valid=0, frame_err=0, overrun=0.
- The FSM has three states: IDLE, DATA and STOP.
- IDLE:
  - sin=0 at an edge: start bit. Go to DATA, counter=0.
  - sin=1: stay in IDLE.
- DATA:
  - Each edge: shift[counter] <= sin, counter++.
  - On the edge that samples bit WIDTH-1: go to STOP, counter=0.
- STOP: sample sin at the edge, then go to IDLE unconditionally.
  - sin=1 (good frame), slot free: out<=shift, valid<=1. The slot is free when valid=0, or when valid&ready=1 at this same edge.
  - sin=1 (good frame), slot occupied: valid=1 and ready=0. Drop the word, leave out unchanged, set overrun<=1.
  - sin=0 (framing error): discard the word, frame_err<=1 for one cycle, leave out/valid unchanged.
- Handshake:
  - valid rises only on a STOP commit.
  - valid falls on an edge with valid&ready=1 and no simultaneous commit.
  - ready while valid=0 has no effect.
- overrun clears only on reset.
- frame_err is 0 on every edge other than a failed STOP sample.
- A start bit is never detected in DATA or STOP; sin there is data or stop only.

## Timing
- Start bit sampled at edge E. Data bits are sampled at E+1..E+WIDTH and the stop bit at E+WIDTH+1. valid/out/frame_err/overrun update at E+WIDTH+1 (E+9 for WIDTH=8).
- Back-to-back frames are supported with no idle gap: a start bit at the edge after STOP (E+WIDTH+2) is detected.
- Consumption latency: valid falls on the edge where ready is sampled high. At most one word is consumed per edge.
- Commit and consume on the same edge: the old word is consumed, the new word is loaded, valid stays 1, and no overrun is flagged.
- Reset mid-frame: the next edge returns to IDLE, and the partial frame is lost without frame_err. A pending valid word is also cleared.
- All outputs are registered, with no combinational path from sin or ready to any output.

## Test plan
- Single frame 0xA5:
  - Stimulus: sin=0 | 1,0,1,0,0,1,0,1 | 1 from edge E, ready=0.
  - Response: valid=1, out=0xA5 after E+9; frame_err=0, overrun=0.
  - Then ready=1 for one edge: valid=0 and out stays 0xA5.
- Framing error:
  - Stimulus: frame 0x3C with stop bit 0.
  - Response: frame_err=1 for exactly the cycle after E+9, valid stays 0, out is unchanged.
  - The next good frame 0x3C is received correctly.
- Overrun:
  - Stimulus: two back-to-back frames 0x11 then 0x22, ready=0 throughout.
  - Response: out=0x11, valid=1, overrun=1 after the second stop bit.
  - After ready consumes: valid=0, and overrun remains 1 until reset.
- Simultaneous consume+commit:
  - Stimulus: out=0x11 pending, ready=1 exactly at the stop-bit edge of frame 0x22.
  - Response: out=0x22, valid=1, overrun=0.
- Reset mid-frame:
  - Stimulus: reset high for one edge after 4 data bits of 0xFF.
  - Response: all outputs 0, state IDLE.
  - The following frame 0x81 yields out=0x81 with no frame_err.
- Idle line and reset state:
  - Stimulus: sin=1 held for 50 cycles after reset.
  - Response: valid, frame_err and overrun stay 0, and out stays 0x00.
